alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_op_decode.sv | 53 +++++
 rtl/alu_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes,
// RV64 major opcodes, FSM state encoding and a small flag helper.
package alu_pkg;

  // ALU operation codes driven on alu_ctrl
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_BEQ = 4'b1010;

  // RV64 major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Controller FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_ISSUE = 2'b01;
  localparam state_t ST_RESP  = 2'b10;

  // Carry/overflow only carry meaning for the arithmetic ops
  function automatic logic op_has_flags(input logic [3:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7b5 into an ALU op code,
// operand-B source select and an illegal-instruction flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl,
  output logic       use_imm,
  output logic       illegal
);

  // Map the supported instruction subset; anything else is flagged illegal
  always_comb begin
    alu_ctrl = ALU_ADD;
    use_imm  = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000:  alu_ctrl = funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          default: illegal  = 1'b1;
        endcase
      end
      OP_I: begin
        // funct7b5 is part of the immediate here, so it is not consulted
        use_imm = 1'b1;
        case (funct3)
          3'b000:  alu_ctrl = ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          default: illegal  = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        // address generation: rs1 + imm
        use_imm = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          alu_ctrl = ALU_BEQ;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issuing end of the 64-bit ALU interface: accepts a decoded instruction,
// drives registered operands to the ALU for one cycle, captures the result
// and flags, and holds a registered response until the consumer takes it.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int IMM_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [IMM_W-1:0] in_imm,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_taken,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_illegal
);

  logic [3:0]      dec_ctrl;
  logic            dec_use_imm;
  logic            dec_illegal;

  state_t          state_q,        state_d;
  logic [XLEN-1:0] alu_a_q,        alu_a_d;
  logic [XLEN-1:0] alu_b_q,        alu_b_d;
  logic [3:0]      alu_ctrl_q,     alu_ctrl_d;
  logic [XLEN-1:0] out_result_q,   out_result_d;
  logic            out_taken_q,    out_taken_d;
  logic            out_carry_q,    out_carry_d;
  logic            out_overflow_q, out_overflow_d;
  logic            out_illegal_q,  out_illegal_d;

  alu_op_decode u_decode (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .alu_ctrl (dec_ctrl),
    .use_imm  (dec_use_imm),
    .illegal  (dec_illegal)
  );

  // Next-state and datapath register updates for IDLE -> ISSUE -> RESP
  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_ctrl_d     = alu_ctrl_q;
    out_result_d   = out_result_q;
    out_taken_d    = out_taken_q;
    out_carry_d    = out_carry_q;
    out_overflow_d = out_overflow_q;
    out_illegal_d  = out_illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (dec_illegal) begin
            // Illegal: skip the ALU entirely; alu_* keeps its old value
            state_d        = ST_RESP;
            out_result_d   = '0;
            out_taken_d    = 1'b0;
            out_carry_d    = 1'b0;
            out_overflow_d = 1'b0;
            out_illegal_d  = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            alu_a_d    = in_rs1;
            alu_b_d    = dec_use_imm ? in_imm[XLEN-1:0] : in_rs2;
            alu_ctrl_d = dec_ctrl;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Operands have been stable for a full cycle; capture the ALU outputs
        state_d        = ST_RESP;
        out_result_d   = alu_result;
        out_carry_d    = op_has_flags(alu_ctrl_q) ? alu_carry    : 1'b0;
        out_overflow_d = op_has_flags(alu_ctrl_q) ? alu_overflow : 1'b0;
        out_taken_d    = (alu_ctrl_q == ALU_BEQ)  ? alu_zero     : 1'b0;
        out_illegal_d  = 1'b0;
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctrl_q     <= ALU_ADD;
      out_result_q   <= '0;
      out_taken_q    <= 1'b0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_ctrl_q     <= alu_ctrl_d;
      out_result_q   <= out_result_d;
      out_taken_q    <= out_taken_d;
      out_carry_q    <= out_carry_d;
      out_overflow_q <= out_overflow_d;
      out_illegal_q  <= out_illegal_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign out_result   = out_result_q;
  assign out_taken    = out_taken_q;
  assign out_carry    = out_carry_q;
  assign out_overflow = out_overflow_q;
  assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural 64-bit ALU, a table of
// directed vectors, hand sequences for backpressure/reset, and random
// instructions checked against a rule-level reference model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [63:0] in_rs1, in_rs2, in_imm;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_result;
  logic        alu_carry, alu_overflow, alu_zero;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        out_taken, out_carry, out_overflow, out_illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [63:0] rs1, rs2, imm;
    logic [63:0] exp_res, exp_b;
    logic [3:0]  exp_ctrl;
    logic        exp_taken, exp_c, exp_o, exp_ill;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        c, o, z;
  } alu_out_t;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(64), .IMM_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_taken(out_taken), .out_carry(out_carry),
    .out_overflow(out_overflow), .out_illegal(out_illegal)
  );

  // Behavioural stand-in for the 64-bit ALU (carry = no-borrow on SUB)
  function automatic alu_out_t alu_fn(input logic [63:0] a, input logic [63:0] b,
                                      input logic [3:0] op);
    alu_out_t r;
    logic [64:0] s;
    r.res = 64'd0; r.c = 1'b0; r.o = 1'b0;
    case (op)
      4'b0000: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[63:0]; r.c = s[64];
        r.o = (a[63] == b[63]) && (r.res[63] != a[63]);
      end
      4'b0001: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r.res = s[63:0]; r.c = s[64];
        r.o = (a[63] != b[63]) && (r.res[63] != a[63]);
      end
      4'b0100: r.res = a & b;
      4'b0101: r.res = a | b;
      4'b1010: r.res = a - b;
      default: r.res = 64'd0;
    endcase
    r.z = (r.res == 64'd0);
    return r;
  endfunction

  // ALU is purely combinational on the controller's registered operands
  always_comb begin
    alu_out_t r;
    r = alu_fn(alu_a, alu_b, alu_ctrl);
    alu_result   = r.res;
    alu_carry    = r.c;
    alu_overflow = r.o;
    alu_zero     = r.z;
  end

  function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic [63:0] rs1, input logic [63:0] rs2,
                              input logic [63:0] imm, input logic [63:0] exp_res,
                              input logic [63:0] exp_b, input logic [3:0] exp_ctrl,
                              input logic exp_taken, input logic exp_c,
                              input logic exp_o, input logic exp_ill);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.exp_res = exp_res; v.exp_b = exp_b; v.exp_ctrl = exp_ctrl;
    v.exp_taken = exp_taken; v.exp_c = exp_c; v.exp_o = exp_o; v.exp_ill = exp_ill;
    return v;
  endfunction

  // Reference model: instruction rules -> expected operands and response
  function automatic vec_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [63:0] rs1, input logic [63:0] rs2,
                                 input logic [63:0] imm);
    vec_t v;
    alu_out_t r;
    bit legal = 1'b1;
    bit imm_src = 1'b0;
    logic [3:0] op = 4'b0000;
    if (opc == 7'b0110011 && f3 == 3'b000)      op = f7 ? 4'b0001 : 4'b0000;
    else if (opc == 7'b0110011 && f3 == 3'b111) op = 4'b0100;
    else if (opc == 7'b0110011 && f3 == 3'b110) op = 4'b0101;
    else if (opc == 7'b0010011 && f3 == 3'b000) begin op = 4'b0000; imm_src = 1'b1; end
    else if (opc == 7'b0010011 && f3 == 3'b111) begin op = 4'b0100; imm_src = 1'b1; end
    else if (opc == 7'b0010011 && f3 == 3'b110) begin op = 4'b0101; imm_src = 1'b1; end
    else if (opc == 7'b0000011 || opc == 7'b0100011) begin op = 4'b0000; imm_src = 1'b1; end
    else if (opc == 7'b1100011 && f3 == 3'b000) op = 4'b1010;
    else legal = 1'b0;
    v = mk(opc, f3, f7, rs1, rs2, imm, 64'd0, imm_src ? imm : rs2, op,
           1'b0, 1'b0, 1'b0, !legal);
    if (legal) begin
      r = alu_fn(rs1, v.exp_b, op);
      v.exp_res   = r.res;
      v.exp_c     = (op == 4'b0000 || op == 4'b0001) ? r.c : 1'b0;
      v.exp_o     = (op == 4'b0000 || op == 4'b0001) ? r.o : 1'b0;
      v.exp_taken = (op == 4'b1010) ? (rs1 == rs2) : 1'b0;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Issue one instruction, check latency/operands/response, hold out_ready low
  // for 'hold' cycles and confirm the response stays put, then retire it.
  task automatic run_vec(input string nm, input vec_t v, input int hold);
    int lat;
    bit seen;
    logic [63:0] pa, pb;
    logic [3:0] pc;
    @(negedge clk);
    chk({nm, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    pa = alu_a; pb = alu_b; pc = alu_ctrl;
    in_opcode = v.opc; in_funct3 = v.f3; in_funct7b5 = v.f7;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Inputs are only sampled at the accept edge; scramble them afterwards
    in_opcode = 7'($urandom); in_funct3 = 3'($urandom); in_funct7b5 = 1'($urandom);
    in_rs1 = {$urandom, $urandom}; in_rs2 = {$urandom, $urandom}; in_imm = {$urandom, $urandom};
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
      else if (lat == 1 && !v.exp_ill) begin
        chk({nm, ".issue_a"}, alu_a, v.rs1);
        chk({nm, ".issue_b"}, alu_b, v.exp_b);
        chk({nm, ".issue_ctrl"}, {60'd0, alu_ctrl}, {60'd0, v.exp_ctrl});
        chk({nm, ".issue_ready"}, {63'd0, in_ready}, 64'd0);
      end
    end
    chk({nm, ".latency"}, 64'(lat), v.exp_ill ? 64'd1 : 64'd2);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk({nm, ".valid"}, {63'd0, out_valid}, 64'd1);
      chk({nm, ".result"}, out_result, v.exp_res);
      chk({nm, ".flags"}, {60'd0, out_taken, out_carry, out_overflow, out_illegal},
          {60'd0, v.exp_taken, v.exp_c, v.exp_o, v.exp_ill});
      if (h > 0) chk({nm, ".hold_ready"}, {63'd0, in_ready}, 64'd0);
    end
    if (v.exp_ill) begin
      chk({nm, ".alu_unchanged"}, alu_a ^ pa ^ alu_b ^ pb, 64'd0);
      chk({nm, ".ctrl_unchanged"}, {60'd0, alu_ctrl}, {60'd0, pc});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, ".retired"}, {62'd0, out_valid, in_ready}, 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [12];
    vec_t v;
    logic [6:0] opcs [6];
    logic [2:0] f3s [4];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
    in_rs1 = 64'd0; in_rs2 = 64'd0; in_imm = 64'd0;

    //        opc          f3      f7    rs1                    rs2                    imm                    exp_res                exp_b                  ctrl     tk    c     o     ill
    tbl[0]  = mk(OP_R,      3'b000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1,                 64'd0,                 64'd0,                 64'd1,                 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(OP_R,      3'b000, 1'b1, 64'h8000000000000000, 64'd1,                 64'd0,                 64'h7FFFFFFFFFFFFFFF, 64'd1,                 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[2]  = mk(OP_BRANCH, 3'b000, 1'b0, 64'h1234,             64'h1234,              64'd0,                 64'd0,                 64'h1234,              4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(OP_BRANCH, 3'b000, 1'b0, 64'h1234,             64'h1235,              64'd0,                 64'hFFFFFFFFFFFFFFFF, 64'h1235,              4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(OP_I,      3'b111, 1'b1, 64'hF0F0,             64'h5555,              64'hFFFFFFFFFFFFFF00, 64'hF000,              64'hFFFFFFFFFFFFFF00, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(OP_I,      3'b110, 1'b0, 64'h0F,               64'h3,                 64'hF0,                64'hFF,                64'hF0,                4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(OP_I,      3'b000, 1'b1, 64'd5,                64'd9,                 64'hFFFFFFFFFFFFFFFF, 64'd4,                 64'hFFFFFFFFFFFFFFFF, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(OP_LOAD,   3'b011, 1'b0, 64'h1000,             64'h77,                64'h20,                64'h1020,              64'h20,                4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(OP_STORE,  3'b010, 1'b1, 64'h7FFFFFFFFFFFFFFF, 64'h0,                 64'd1,                 64'h8000000000000000, 64'd1,                 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(OP_R,      3'b111, 1'b0, 64'hFF00,             64'h0FF0,              64'd0,                 64'h0F00,              64'h0FF0,              4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(OP_R,      3'b001, 1'b0, 64'd3,                64'd4,                 64'd0,                 64'd0,                 64'd0,                 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(OP_BRANCH, 3'b001, 1'b0, 64'd3,                64'd3,                 64'd0,                 64'd0,                 64'd0,                 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
    chk("reset.alu_a", alu_a, 64'd0);
    chk("reset.alu_b", alu_b, 64'd0);
    chk("reset.alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
    chk("reset.out_result", out_result, 64'd0);
    chk("reset.out_flags", {60'd0, out_taken, out_carry, out_overflow, out_illegal}, 64'd0);

    for (int i = 0; i < 12; i++) run_vec($sformatf("tbl%0d", i), tbl[i], 0);

    // Illegal SYSTEM opcode under 5 cycles of backpressure
    run_vec("illegal_hold",
            mk(7'b1110011, 3'b000, 1'b0, 64'd1, 64'd2, 64'd3, 64'd0, 64'd0, 4'b0000,
               1'b0, 1'b0, 1'b0, 1'b1), 5);
    // Legal op under backpressure
    run_vec("sub_hold", model(OP_R, 3'b000, 1'b1, 64'd10, 64'd3, 64'd0), 3);

    // Reset asserted while an ADD is in ISSUE
    @(negedge clk);
    in_opcode = OP_R; in_funct3 = 3'b000; in_funct7b5 = 1'b0;
    in_rs1 = 64'd7; in_rs2 = 64'd8; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid.in_issue", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.ready_valid", {62'd0, in_ready, out_valid}, 64'd2);
    chk("rst_mid.out_result", out_result, 64'd0);
    chk("rst_mid.alu", alu_a | alu_b | {60'd0, alu_ctrl}, 64'd0);
    @(negedge clk);
    chk("rst_mid.still_idle", {62'd0, in_ready, out_valid}, 64'd2);
    out_ready = 1'b0;
    run_vec("after_rst", tbl[0], 0);
    run_vec("add_2_3", mk(OP_R, 3'b000, 1'b0, 64'd2, 64'd3, 64'd0, 64'd5, 64'd3, 4'b0000,
                          1'b0, 1'b0, 1'b0, 1'b0), 0);

    // Randomized instructions against the reference model
    opcs[0] = OP_R; opcs[1] = OP_I; opcs[2] = OP_LOAD;
    opcs[3] = OP_STORE; opcs[4] = OP_BRANCH; opcs[5] = 7'b1110011;
    f3s[0] = 3'b000; f3s[1] = 3'b110; f3s[2] = 3'b111; f3s[3] = 3'b000;
    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      logic [2:0] f;
      logic [63:0] a, b;
      o = opcs[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) o = 7'($urandom);
      f = ($urandom_range(0, 4) == 0) ? 3'($urandom) : f3s[$urandom_range(0, 3)];
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 1) == 1) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'h8000000000000000 | 64'($urandom);
      v = model(o, f, 1'($urandom), a, b, {{32{1'b1}}, $urandom});
      run_vec($sformatf("rand%0d", n), v, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
